// File: rtl/ls_reg_file.sv
// Multi-entry load/store register bank: one synchronous write port, two
// combinational read ports, optional write-through bypass and hard-wired zero entry.
module ls_reg_file #(
    parameter int N       = 4,
    parameter int AW      = 2,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          sclr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [N-1:0]  rdata_a,
    output logic          vld_a,
    input  logic [AW-1:0] raddr_b,
    output logic [N-1:0]  rdata_b,
    output logic          vld_b
);

    localparam int ENTRIES = 2 ** AW;

    logic [N-1:0]       mem [ENTRIES];
    logic [ENTRIES-1:0] wr_flag;
    logic               r0_drop;
    logic               wr_go;
    logic               byp_en;

    // A write to the hard-wired zero entry is dropped entirely.
    assign r0_drop = (R0_ZERO != 0) && (waddr == '0);
    assign wr_go   = we && !sclr && !r0_drop;
    assign byp_en  = (BYPASS != 0) && wr_go && clr;

    // NOTE: the storage array sits on the async reset because a clear must zero
    // every entry immediately, not just the valid flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
            wr_flag <= '0;
        end else if (sclr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
            wr_flag <= '0;
        end else if (wr_go) begin
            mem[waddr]     <= wdata;
            wr_flag[waddr] <= 1'b1;
        end
    end

    // Returns {vld, rdata} for one read port; the zero entry overrides bypass.
    function automatic logic [N:0] read_entry(
        input logic [AW-1:0] ra,
        input logic [N-1:0]  stored,
        input logic          flag,
        input logic          bypass,
        input logic [AW-1:0] wa,
        input logic [N-1:0]  wd
    );
        logic [N:0] res;
        res = {flag, stored};
        if (bypass && (ra == wa)) begin
            res = {1'b1, wd};
        end
        if ((R0_ZERO != 0) && (ra == '0)) begin
            res = {1'b1, {N{1'b0}}};
        end
        return res;
    endfunction

    assign {vld_a, rdata_a} = read_entry(raddr_a, mem[raddr_a], wr_flag[raddr_a],
                                         byp_en, waddr, wdata);
    assign {vld_b, rdata_b} = read_entry(raddr_b, mem[raddr_b], wr_flag[raddr_b],
                                         byp_en, waddr, wdata);

endmodule

// File: tb/tb_ls_reg_file.sv
// Self-checking bench for ls_reg_file: three configurations share one stimulus
// stream and are compared every cycle against an array-based reference model.
module tb_ls_reg_file;

    logic       clk;
    logic       clr;
    logic       sclr;
    logic       we;
    logic [1:0] waddr;
    logic [3:0] wdata;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;

    logic [3:0] rd_a [3];
    logic [3:0] rd_b [3];
    logic       v_a  [3];
    logic       v_b  [3];

    // Configurations: 0 = bypass, 1 = no bypass, 2 = bypass with zero entry.
    int byp [3] = '{1, 0, 1};
    int r0  [3] = '{0, 0, 1};

    logic [3:0] m_mem  [3][4];
    logic       m_flag [3][4];

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    ls_reg_file #(.N(4), .AW(2), .BYPASS(1), .R0_ZERO(0)) dut0 (
        .clk(clk), .clr(clr), .sclr(sclr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[0]), .vld_a(v_a[0]),
        .raddr_b(raddr_b), .rdata_b(rd_b[0]), .vld_b(v_b[0]));

    ls_reg_file #(.N(4), .AW(2), .BYPASS(0), .R0_ZERO(0)) dut1 (
        .clk(clk), .clr(clr), .sclr(sclr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[1]), .vld_a(v_a[1]),
        .raddr_b(raddr_b), .rdata_b(rd_b[1]), .vld_b(v_b[1]));

    ls_reg_file #(.N(4), .AW(2), .BYPASS(1), .R0_ZERO(1)) dut2 (
        .clk(clk), .clr(clr), .sclr(sclr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[2]), .vld_a(v_a[2]),
        .raddr_b(raddr_b), .rdata_b(rd_b[2]), .vld_b(v_b[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got vld/data=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference: state changes only on a clear or an accepted write.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int c = 0; c < 3; c++)
                for (int a = 0; a < 4; a++) begin
                    m_mem[c][a]  <= 4'h0;
                    m_flag[c][a] <= 1'b0;
                end
        end else if (sclr) begin
            for (int c = 0; c < 3; c++)
                for (int a = 0; a < 4; a++) begin
                    m_mem[c][a]  <= 4'h0;
                    m_flag[c][a] <= 1'b0;
                end
        end else if (we) begin
            for (int c = 0; c < 3; c++)
                if (!(r0[c] != 0 && waddr == 2'd0)) begin
                    m_mem[c][waddr]  <= wdata;
                    m_flag[c][waddr] <= 1'b1;
                end
        end
    end

    function automatic logic [4:0] expect_read(input int c, input logic [1:0] ra);
        if (r0[c] != 0 && ra == 2'd0) return 5'h10;
        if (!clr) return 5'h00;
        if (byp[c] != 0 && we && !sclr && ra == waddr && !(r0[c] != 0 && waddr == 2'd0))
            return {1'b1, wdata};
        return {m_flag[c][ra], m_mem[c][ra]};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("cmp_a%0d", c), {v_a[c], rd_a[c]}, expect_read(c, raddr_a));
                check($sformatf("cmp_b%0d", c), {v_b[c], rd_b[c]}, expect_read(c, raddr_b));
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge, return just after the falling edge.
    task automatic cyc(input logic s, input logic w, input logic [1:0] wa,
                       input logic [3:0] wd, input logic [1:0] ra, input logic [1:0] rb);
        @(posedge clk);
        #1;
        sclr = s; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_a(input int d, input string n, input logic v, input logic [3:0] x);
        check(n, {v_a[d], rd_a[d]}, {v, x});
    endtask

    task automatic chk_b(input int d, input string n, input logic v, input logic [3:0] x);
        check(n, {v_b[d], rd_b[d]}, {v, x});
    endtask

    initial begin
        clr = 1'b1; sclr = 1'b0; we = 1'b0; waddr = 2'd0; wdata = 4'h0;
        raddr_a = 2'd0; raddr_b = 2'd3;
        #2 clr = 1'b0;
        #1;
        chk_a(0, "rst_a0", 1'b0, 4'h0);
        chk_b(0, "rst_b0", 1'b0, 4'h0);
        chk_a(2, "rst_r0_vld", 1'b1, 4'h0);
        #5 clr = 1'b1;
        started = 1;

        cyc(0, 1, 2'd1, 4'h3, 2'd0, 2'd0);
        cyc(0, 1, 2'd2, 4'hA, 2'd0, 2'd0);
        cyc(0, 0, 2'd0, 4'h0, 2'd1, 2'd2);
        chk_a(0, "rd_a1", 1'b1, 4'h3);
        chk_b(0, "rd_b2", 1'b1, 4'hA);
        chk_b(1, "rd_b2_nobyp", 1'b1, 4'hA);
        cyc(0, 0, 2'd0, 4'h0, 2'd3, 2'd2);
        chk_a(0, "unwritten3", 1'b0, 4'h0);

        for (int i = 0; i < 5; i++)
            cyc(0, 0, 2'($urandom_range(0, 3)), (i % 2 == 0) ? 4'hF : 4'h0, 2'd1, 2'd2);
        chk_a(0, "hold_a1", 1'b1, 4'h3);

        cyc(0, 1, 2'd3, 4'h7, 2'd3, 2'd3);
        chk_a(0, "bypass_on", 1'b1, 4'h7);
        chk_a(1, "bypass_off", 1'b0, 4'h0);
        cyc(0, 0, 2'd0, 4'h0, 2'd3, 2'd3);
        chk_a(1, "nobyp_after", 1'b1, 4'h7);

        cyc(1, 1, 2'd2, 4'hF, 2'd2, 2'd1);
        chk_a(0, "sclr_preclear", 1'b1, 4'hA);
        cyc(0, 0, 2'd0, 4'h0, 2'd2, 2'd1);
        chk_a(0, "sclr_a2", 1'b0, 4'h0);
        chk_b(0, "sclr_b1", 1'b0, 4'h0);

        cyc(0, 1, 2'd1, 4'h6, 2'd1, 2'd0);
        cyc(0, 0, 2'd0, 4'h0, 2'd1, 2'd0);
        chk_a(0, "loaded_a1", 1'b1, 4'h6);
        clr = 1'b0;
        #1;
        chk_a(0, "async_clr_a1", 1'b0, 4'h0);
        chk_b(2, "async_clr_r0", 1'b1, 4'h0);
        #1 clr = 1'b1;
        cyc(0, 1, 2'd0, 4'h5, 2'd0, 2'd0);
        cyc(0, 0, 2'd0, 4'h0, 2'd0, 2'd0);
        chk_a(0, "post_clr_a0", 1'b1, 4'h5);
        chk_a(1, "post_clr_a0_nb", 1'b1, 4'h5);

        cyc(0, 1, 2'd0, 4'h9, 2'd0, 2'd0);
        chk_a(2, "r0_write_in", 1'b1, 4'h0);
        chk_a(0, "r0_off_byp", 1'b1, 4'h9);
        cyc(0, 0, 2'd0, 4'h0, 2'd0, 2'd0);
        chk_a(2, "r0_write_after", 1'b1, 4'h0);
        cyc(0, 1, 2'd1, 4'h9, 2'd1, 2'd1);
        cyc(0, 0, 2'd0, 4'h0, 2'd1, 2'd0);
        chk_a(2, "r0_addr1", 1'b1, 4'h9);
        chk_b(2, "r0_addr0", 1'b1, 4'h0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 39) == 0) begin
                clr = 1'b0;
                #1;
                chk_a(0, "rand_async_a", 1'b0, 4'h0);
                #1 clr = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ls_reg_file.md
Name: ls_reg_file

Overview:
Parametrised multi-entry successor to the single load/store register: a bank of 2**AW registers, each N bits wide, for the processor datapath. It has one synchronous write port and two combinational read ports. An optional write-through bypass, an optional hard-wired-zero register 0, and per-entry "written" flags let the control unit detect reads of never-loaded registers. It sits between the ALU result bus and the ALU operand muxes.

Parameters:
N, 4, data width in bits
AW, 2, address width; number of entries = 2**AW
BYPASS, 1, 1 = a read of the address being written this cycle returns wdata; 0 = returns stored value
R0_ZERO, 0, 1 = entry 0 always reads 0, is always flagged written, and ignores writes

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  asynchronous active-low reset; clears all entries and flags
sclr  input  1  synchronous active-high clear-all command
we  input  1  write enable (1 = load, 0 = store/hold)
waddr  input  AW  write address
wdata  input  N  write data
raddr_a  input  AW  read port A address
rdata_a  output  N  read port A data
vld_a  output  1  entry at raddr_a has been written since last clear
raddr_b  input  AW  read port B address
rdata_b  output  N  read port B data
vld_b  output  1  entry at raddr_b has been written since last clear

Behaviour:
- State: mem[0..2**AW-1] (N bits each) and wr_flag[0..2**AW-1] (1 bit each).
- clr=0, asynchronous, at any time including mid-write: all mem = 0 and all wr_flag = 0 immediately, held while clr=0.
  - If R0_ZERO=1, wr_flag[0] reads as 1 regardless.
- Rising clk with clr=1, priority sclr > we:
  - sclr=1: all mem and wr_flag cleared to 0; a we in the same cycle is discarded.
  - sclr=0, we=1: mem[waddr] <= wdata and wr_flag[waddr] <= 1.
  - R0_ZERO=1 and waddr=0: the write is dropped and no state changes.
  - sclr=0, we=0: all entries hold.
- Reads are combinational with zero latency. rdata_x = mem[raddr_x] and vld_x = wr_flag[raddr_x], for x = a, b.
- Bypass (BYPASS=1): when we=1, sclr=0, clr=1 and raddr_x == waddr (and not an R0_ZERO-dropped write), then rdata_x = wdata and vld_x = 1 in that same cycle.
  - Bypass is suppressed when sclr=1.
  - Bypass is suppressed when clr=0, where outputs are 0.
- R0_ZERO=1: a read of address 0 returns rdata=0 and vld=1 always, including with bypass active.
- Both ports may read the same address simultaneously, with identical results.
- Reset value of outputs: rdata_a = rdata_b = 0 and vld_a = vld_b = 0, except address 0 when R0_ZERO=1 (vld=1).
- No wrap or overflow behaviour: every AW-bit address is valid and no out-of-range case exists.

Test Plan:
- Reset, then write loop (N=4, AW=2, BYPASS=1, R0_ZERO=0): pulse clr low mid-cycle. Write 0x3 to addr1, 0xA to addr2. Read A=1, B=2 -> rdata_a=0x3, vld_a=1, rdata_b=0xA, vld_b=1. Read A=3 -> 0x0, vld_a=0.
- Hold: we=0 for 5 cycles with wdata toggling -> all entries unchanged; addr1 still reads 0x3.
- Bypass: we=1, waddr=3, wdata=0x7, raddr_a=3 in the same cycle -> rdata_a=0x7, vld_a=1 before the edge. With BYPASS=0 -> rdata_a=0x0, vld_a=0 until after the edge, then 0x7.
- sclr vs we: sclr=1, we=1, waddr=2, wdata=0xF -> after the edge all entries read 0 with vld=0, and addr2 is not 0xF. During that cycle, raddr_a=2 shows the pre-clear value 0xA, not the bypassed value.
- Async reset mid-operation: with entries loaded, drive clr=0 between edges -> rdata and vld drop to 0 immediately without a clock edge. Release clr; the next write of 0x5 to addr0 reads back 0x5.
- R0_ZERO=1: write 0x9 to addr0 with raddr_a=0 -> rdata_a=0, vld_a=1 both in the cycle and after it. Write 0x9 to addr1 -> reads back 0x9.
